// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - datapath-side bundle: instruction fetch address/data and write strobes
interface cpu_sequencer_if #(
  parameter int AW = 3
);
  logic [AW-1:0] instr_addr;
  logic [31:0]   instr;
  logic          RegWrite;
  logic          MemWrite;

  modport master (output instr_addr, output RegWrite, output MemWrite, input instr);
  modport slave  (input instr_addr, input RegWrite, input MemWrite, output instr);
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - sequences PC, fetch wait and one-cycle write strobes for the single-cycle datapath
module cpu_sequencer #(
  parameter int          AW         = 3,
  parameter int          LAST_ADDR  = 7,
  parameter int          WRAP       = 1,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int          FETCH_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 step,
  input  logic                 reg_we_en,
  input  logic                 mem_we_en,
  cpu_sequencer_if.master      bus,
  output logic                 busy,
  output logic                 halted,
  output logic [7:0]           retired,
  output logic [2:0]           state_dbg
);

  localparam int WW = (FETCH_WAIT > 1) ? $clog2(FETCH_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    ADV   = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr_q;
  logic [WW-1:0] wait_cnt;
  logic          step_q;
  logic          reg_en_l, mem_en_l;
  logic          step_rise;
  logic          at_last;

  assign step_rise = step & ~step_q & ~run;
  assign at_last   = (addr_q == AW'(LAST_ADDR));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run || step_rise) state_n = FETCH;
      FETCH:   if (wait_cnt == '0) state_n = EXEC;
      EXEC:    state_n = (bus.instr == HALT_WORD) ? HALT : WB;
      WB:      state_n = ADV;
      ADV: begin
        if (at_last && (WRAP == 0)) state_n = HALT;
        else if (run)               state_n = FETCH;
        else                        state_n = IDLE;
      end
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wait_cnt <= '0;
      step_q   <= 1'b0;
      reg_en_l <= 1'b0;
      mem_en_l <= 1'b0;
      retired  <= 8'd0;
    end else begin
      state  <= state_n;
      step_q <= step;
      // Reload the fetch wait on every entry into FETCH, whether from IDLE or ADV.
      if (state_n == FETCH && state != FETCH)
        wait_cnt <= WW'(FETCH_WAIT - 1);
      else if (state == FETCH && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (state == EXEC) begin
        reg_en_l <= reg_we_en;
        mem_en_l <= mem_we_en;
      end
      if (state == ADV) begin
        if (retired != 8'hFF) retired <= retired + 8'd1;
        if (!at_last)         addr_q  <= addr_q + 1'b1;
        else if (WRAP != 0)   addr_q  <= '0;
      end
    end
  end

  // Strobes decode only registered state, so instr never reaches them combinationally.
  assign bus.instr_addr = addr_q;
  assign bus.RegWrite   = (state == WB) & reg_en_l;
  assign bus.MemWrite   = (state == WB) & mem_en_l;
  assign busy           = (state == FETCH) || (state == EXEC) || (state == WB) || (state == ADV);
  assign halted         = (state == HALT);
  assign state_dbg      = state;

endmodule
